// File: rtl/booth_mul_4bit.sv
// rtl/booth_mul_4bit.sv - sequential radix-2 Booth multiplier, 4x4 signed -> 8-bit product
module booth_mul_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] acc;
  logic [3:0] q;
  logic       q_1;
  logic [4:0] m;
  logic [1:0] cnt;

  logic [4:0] sum;
  logic [4:0] acc_nxt;
  logic [3:0] q_nxt;
  logic       q_1_nxt;

  // One Booth step: add/subtract M by the {Q[0],Q_1} pair, then arithmetic shift right.
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc + ~m + 5'd1;
      default: sum = acc;
    endcase
    acc_nxt = {sum[4], sum[4:1]};
    q_nxt   = {sum[0], q[3:1]};
    q_1_nxt = q[0];
  end

  // FSM and datapath registers; busy/done/product are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= 5'd0;
      q       <= 4'd0;
      q_1     <= 1'b0;
      m       <= 5'd0;
      cnt     <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= {a[3], a};
            q     <= b;
            acc   <= 5'd0;
            q_1   <= 1'b0;
            cnt   <= 2'd0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          q_1 <= q_1_nxt;
          cnt <= cnt + 2'd1;
          // Last step: the shifted result is already the final product, capture it now.
          if (cnt == 2'd3) begin
            product <= {acc_nxt[3:0], q_nxt};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_4bit.sv
// tb/tb_booth_mul_4bit.sv - directed, table-driven and sweep checks for booth_mul_4bit
module tb_booth_mul_4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;

  booth_mul_4bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // busy and done must never be high together
  always @(negedge clk) begin
    if (rst_n && busy && done) begin
      checks++;
      errors++;
      $display("FAIL busy_done_overlap: got 1 expected 0");
    end
  end

  // Single start pulse; checks the busy/done timeline, product, and one-cycle done.
  task automatic mul_op(input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] exp);
    logic [5:0] bseq;
    logic [5:0] dseq;
    @(negedge clk);
    a = ta;
    b = tb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bseq = '0;
    dseq = '0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      bseq[5-k] = busy;
      dseq[5-k] = done;
      if (k == 4) chk($sformatf("product a=%0d b=%0d", $signed(ta), $signed(tb)), {24'd0, product}, {24'd0, exp});
      if (k == 5) chk("product_hold", {24'd0, product}, {24'd0, exp});
    end
    chk("busy_timeline", {26'd0, bseq}, {26'd0, 6'b111100});
    chk("done_timeline", {26'd0, dseq}, {26'd0, 6'b000010});
  endtask

  initial begin
    int ndone;
    logic [7:0] sexp;
    rst_n = 1'b0;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;

    vecs[0] = '{4'd3,  4'd2,  8'h06};
    vecs[1] = '{4'h8,  4'h8,  8'h40};
    vecs[2] = '{4'h8,  4'd7,  8'hC8};
    vecs[3] = '{4'd7,  4'd7,  8'h31};
    vecs[4] = '{4'd0,  4'hB,  8'h00};
    vecs[5] = '{4'hF,  4'hF,  8'h01};
    vecs[6] = '{4'hF,  4'd7,  8'hF9};
    vecs[7] = '{4'd5,  4'hD,  8'hF1};
    vecs[8] = '{4'h8,  4'd1,  8'hF8};
    vecs[9] = '{4'd4,  4'h8,  8'hE0};

    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", {24'd0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) mul_op(vecs[i].va, vecs[i].vb, vecs[i].exp);

    // Exhaustive sweep with random gaps
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        sexp = 8'($signed(4'(ia)) * $signed(4'(ib)));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        mul_op(4'(ia), 4'(ib), sexp);
      end
    end

    // start re-pulsed mid-CALC with new operands is ignored
    @(negedge clk);
    a = 4'd7;
    b = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a = 4'h8;
        b = 4'h8;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) ndone++;
      if (k == 4) begin
        chk("repulse_done_at_n4", {31'd0, done}, 32'd1);
        chk("repulse_product", {24'd0, product}, 32'h31);
      end
    end
    chk("repulse_done_count", ndone, 1);

    // Async reset mid-CALC aborts the operation
    @(negedge clk);
    a = 4'd3;
    b = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", {24'd0, product}, 32'd0);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    mul_op(4'hD, 4'd5, 8'hF1);

    // start held high through reset release, then continuously
    @(negedge clk);
    rst_n = 1'b0;
    a = 4'h9;
    b = 4'hA;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("start_at_release_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk($sformatf("cont_done k=%0d", k), {31'd0, done}, {31'd0, (k % 6) == 4});
      chk($sformatf("cont_product k=%0d", k), {24'd0, product}, (k >= 4) ? 32'h2A : 32'h00);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mul_4bit.md
BOOTH_MUL_4BIT -- requirements
Module: booth_mul_4bit

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to begin a multiply, sampled on rising clk.
REQ-005 a  input  4  multiplicand, two's complement signed.
REQ-006 b  input  4  multiplier, two's complement signed.
REQ-007 busy  output  1  high while a multiply is in progress (CALC state).
REQ-008 done  output  1  one-cycle pulse marking product valid (DONE state).
REQ-009 product  output  8  signed result a*b, two's complement.

Function
REQ-010 The block SHALL implement sequential radix-2 Booth multiplication, one Booth step per clock.
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-012 Internal state SHALL be: 5-bit accumulator ACC, 4-bit multiplier register Q, 1-bit Q_1, 5-bit multiplicand register M (a sign-extended), 2-bit step counter CNT.
REQ-013 IDLE + start=1 at edge N SHALL load M={a[3],a}, Q=b, ACC=0, Q_1=0, CNT=0, and enter CALC.
REQ-014 IDLE + start=0 SHALL remain in IDLE with all registers held.
REQ-015 Each CALC edge SHALL inspect {Q[0],Q_1}: 01 -> ACC+M; 10 -> ACC-M; 00/11 -> ACC unchanged.
REQ-016 Subtraction SHALL be ACC + ~M + 1, using 5-bit wrap-around arithmetic.
REQ-017 After the add/sub, the same edge SHALL arithmetic-shift {ACC,Q,Q_1} right by one bit, replicating the ACC sign bit, then increment CNT.
REQ-018 The edge that performs step CNT=3 SHALL be edge N+4; it SHALL move the FSM to DONE.
REQ-019 In DONE, product SHALL equal {ACC[3:0],Q} and done SHALL be 1 for exactly one cycle.
REQ-020 The next edge SHALL return the FSM from DONE to IDLE unconditionally.
REQ-021 product SHALL hold its value in IDLE until the next DONE, or until reset.
REQ-022 busy SHALL be 1 only in CALC; done SHALL be 1 only in DONE; busy and done SHALL never both be 1.
REQ-023 start SHALL be ignored in CALC and DONE; a and b SHALL be sampled only at the accepting edge.
REQ-024 Changes on a or b after acceptance SHALL NOT affect the result in progress.
REQ-025 Latency SHALL be fixed: start accepted at edge N -> done high in the cycle after edge N+4.
REQ-026 Back-to-back throughput SHALL be one result per 6 cycles (start re-accepted at edge N+6 at the earliest).
REQ-027 All signed products, including -8*-8=+64, SHALL be exact; no overflow is possible and no overflow flag is provided.

Reset
REQ-028 rst_n=0 SHALL immediately, with no clock required, force state=IDLE, busy=0, done=0, product=8'h00, and ACC, Q, Q_1, M, CNT to 0.
REQ-029 Reset asserted mid-CALC or in DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-030 After rst_n rises, the first start SHALL be accepted normally.
REQ-031 start held high during or at reset release SHALL be accepted at the first rising edge with rst_n=1.

Verification
REQ-032 a=3, b=2, start pulsed at edge N -> busy=1 in cycles N..N+3, done=1 after edge N+4, product=8'h06.
REQ-033 Each of the following SHALL be run with a single start pulse: a=-8, b=-8 -> product=8'h40 (+64); a=-8, b=7 -> 8'hC8 (-56); a=7, b=7 -> 8'h31 (49); a=0, b=-5 -> 8'h00.
REQ-034 Exhaustive sweep of all 256 (a,b) pairs, with random start gaps -> every product equals $signed(a)*$signed(b) and each done is exactly 1 cycle wide.
REQ-035 start re-pulsed mid-CALC with different a/b -> ignored; the original product is delivered at N+4 and no extra done pulse occurs.
REQ-036 rst_n pulsed low for a partial cycle at N+2 -> busy, done and product go to 0 asynchronously, no done pulse follows, and the next start (a=-3, b=5) yields 8'hF1.
REQ-037 start held high continuously -> done pulses every 6 cycles and product remains stable between pulses.
